// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for the HD44780 byte writer.
//   - top/pulse FSM state encodings
//   - nibble request payload handed from the sequencer to the pulse generator
//   - init nibbles, configuration byte table, slow-command detection
package lcd_byte_writer_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    INIT_NIB,
    INIT_WAIT,
    CFG,
    IDLE,
    NIB_HI,
    GAP,
    NIB_LO,
    SETTLE
  } topState_t;

  typedef enum logic [1:0] {
    PULSE_IDLE,
    SETUP,
    EHIGH,
    HOLD
  } pulseState_t;

  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
  } lcdNibble_t;

  localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;

  // Function set 4-bit/2-line, entry mode, display on, clear.
  function automatic logic [7:0] cfgByte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Clear and home need the long settle time.
  function automatic logic isSlowCmd(input logic [7:0] b, input logic rs);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_nibble_pulse.sv
// One LCD bus write: drives D/RS, waits setup, raises E, holds, releases.
//   Clock, Reset     clock, async active-low reset
//   start            begin a pulse (sampled only when idle)
//   req              nibble + RS to put on the bus
//   doneC            high in the last HOLD cycle (combinational)
//   oLCD_E/RS/D      registered LCD bus outputs
module lcd_nibble_pulse
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned P_SETUP_CYC = 2,
  parameter int unsigned P_EHIGH_CYC = 12,
  parameter int unsigned P_HOLD_CYC  = 2,
  parameter int unsigned P_CNT_W     = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  lcdNibble_t req,
  output logic       doneC,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic [3:0] oLCD_D
);

  pulseState_t        state;
  logic [P_CNT_W-1:0] cnt;

  // Early done lets the sequencer chain the next phase without a bubble.
  assign doneC = (state == HOLD) && (cnt == '0);

  // Each phase loads N-1 on entry and leaves when the count reaches zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= PULSE_IDLE;
      cnt     <= '0;
      oLCD_E  <= 1'b0;
      oLCD_RS <= 1'b0;
      oLCD_D  <= 4'h0;
    end else begin
      case (state)
        PULSE_IDLE: begin
          if (start) begin
            state   <= SETUP;
            cnt     <= P_CNT_W'(P_SETUP_CYC - 1);
            oLCD_D  <= req.nib;
            oLCD_RS <= req.rs;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= EHIGH;
            cnt    <= P_CNT_W'(P_EHIGH_CYC - 1);
            oLCD_E <= 1'b1;
          end else begin
            cnt <= cnt - P_CNT_W'(1);
          end
        end
        EHIGH: begin
          if (cnt == '0) begin
            state  <= HOLD;
            cnt    <= P_CNT_W'(P_HOLD_CYC - 1);
            oLCD_E <= 1'b0;
          end else begin
            cnt <= cnt - P_CNT_W'(1);
          end
        end
        default: begin
          if (cnt == '0) begin
            state <= PULSE_IDLE;
          end else begin
            cnt <= cnt - P_CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit byte writer: runs power-on init, then writes one byte per
// valid/ready handshake as high nibble, gap, low nibble, settle.
//   Clock, Reset     50 MHz clock, async active-low reset
//   iData/iRS        byte and register select, latched on accept
//   iValid           write request, accepted when oReady=1
//   oReady           high only in IDLE
//   oInitDone        sticky, set when init completes
//   oDropped         sticky, a request seen while busy was withdrawn unaccepted
//   oLCD_E/RS/RW/D   LCD bus (RW tied low)
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned P_PWRUP_CYC = 750000,
  parameter int unsigned P_INIT1_CYC = 205000,
  parameter int unsigned P_INIT2_CYC = 5000,
  parameter int unsigned P_SETUP_CYC = 2,
  parameter int unsigned P_EHIGH_CYC = 12,
  parameter int unsigned P_HOLD_CYC  = 2,
  parameter int unsigned P_GAP_CYC   = 50,
  parameter int unsigned P_BYTE_CYC  = 2000,
  parameter int unsigned P_CLEAR_CYC = 82000,
  parameter int unsigned P_CNT_W     = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oDropped,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D
);

  topState_t          state;
  logic [P_CNT_W-1:0] cnt;
  logic [7:0]         byteReg;
  logic               rsReg;
  logic [1:0]         initIdx;
  logic [1:0]         cfgIdx;
  logic               startReg;
  logic               waitReq;
  logic               pulseDone;
  logic               pulseStart;
  logic               gapEnd;
  lcdNibble_t         pulseReq;
  logic [P_CNT_W-1:0] initWaitLoad;
  logic [P_CNT_W-1:0] settleLoad;

  assign oLCD_RW = 1'b0;

  // Low nibble is launched from the last GAP cycle so the gap is exact.
  assign gapEnd     = (state == GAP) && (cnt == '0);
  assign pulseStart = startReg || gapEnd;

  // Nibble presented to the pulse generator for whichever phase is starting.
  always_comb begin
    pulseReq = '{rs: rsReg, nib: byteReg[7:4]};
    if (state == INIT_NIB) begin
      pulseReq = '{rs: 1'b0, nib: (initIdx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE};
    end else if (state == GAP) begin
      pulseReq.nib = byteReg[3:0];
    end
  end

  // Per-step waits after each raw init nibble.
  always_comb begin
    case (initIdx)
      2'd0:    initWaitLoad = P_CNT_W'(P_INIT1_CYC - 1);
      2'd1:    initWaitLoad = P_CNT_W'(P_INIT2_CYC - 1);
      default: initWaitLoad = P_CNT_W'(P_BYTE_CYC - 1);
    endcase
  end

  assign settleLoad = isSlowCmd(byteReg, rsReg) ? P_CNT_W'(P_CLEAR_CYC - 1)
                                                : P_CNT_W'(P_BYTE_CYC - 1);

  lcd_nibble_pulse #(
    .P_SETUP_CYC(P_SETUP_CYC),
    .P_EHIGH_CYC(P_EHIGH_CYC),
    .P_HOLD_CYC (P_HOLD_CYC),
    .P_CNT_W    (P_CNT_W)
  ) uPulse (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (pulseStart),
    .req    (pulseReq),
    .doneC  (pulseDone),
    .oLCD_E (oLCD_E),
    .oLCD_RS(oLCD_RS),
    .oLCD_D (oLCD_D)
  );

  // Sequencer: init nibbles, config bytes, then the handshake byte path.
  // Reset is the PWRUP entry, so the power-up wait is loaded there.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= PWRUP;
      cnt       <= P_CNT_W'(P_PWRUP_CYC - 1);
      byteReg   <= 8'h00;
      rsReg     <= 1'b0;
      initIdx   <= 2'd0;
      cfgIdx    <= 2'd0;
      startReg  <= 1'b0;
      waitReq   <= 1'b0;
      oReady    <= 1'b0;
      oInitDone <= 1'b0;
      oDropped  <= 1'b0;
    end else begin
      startReg <= 1'b0;
      // A request held until IDLE is served; one withdrawn while busy is lost.
      waitReq  <= iValid && !oReady;
      if (waitReq && !iValid) oDropped <= 1'b1;

      case (state)
        PWRUP: begin
          if (cnt == '0) begin
            state    <= INIT_NIB;
            initIdx  <= 2'd0;
            startReg <= 1'b1;
          end else begin
            cnt <= cnt - P_CNT_W'(1);
          end
        end
        INIT_NIB: begin
          if (pulseDone) begin
            state <= INIT_WAIT;
            cnt   <= initWaitLoad;
          end
        end
        INIT_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - P_CNT_W'(1);
          end else if (initIdx == 2'd3) begin
            state  <= CFG;
            cfgIdx <= 2'd0;
          end else begin
            state    <= INIT_NIB;
            initIdx  <= initIdx + 2'd1;
            startReg <= 1'b1;
          end
        end
        CFG: begin
          byteReg  <= cfgByte(cfgIdx);
          rsReg    <= 1'b0;
          state    <= NIB_HI;
          startReg <= 1'b1;
        end
        IDLE: begin
          if (iValid) begin
            byteReg  <= iData;
            rsReg    <= iRS;
            state    <= NIB_HI;
            startReg <= 1'b1;
            oReady   <= 1'b0;
          end
        end
        NIB_HI: begin
          if (pulseDone) begin
            state <= GAP;
            cnt   <= P_CNT_W'(P_GAP_CYC - 1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= NIB_LO;
          end else begin
            cnt <= cnt - P_CNT_W'(1);
          end
        end
        NIB_LO: begin
          if (pulseDone) begin
            state <= SETTLE;
            cnt   <= settleLoad;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - P_CNT_W'(1);
          end else if (oInitDone || (cfgIdx == 2'd3)) begin
            state     <= IDLE;
            oReady    <= 1'b1;
            oInitDone <= 1'b1;
          end else begin
            state  <= CFG;
            cfgIdx <= cfgIdx + 2'd1;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule
